// File: rtl/alu_op_sequencer_if.sv
// Bus bundle between the instruction source / ALU and the register-to-register
// ALU sequencer. The master side drives instructions, loads and ALU results.
interface alu_op_sequencer_if;
  logic       InsValid;
  logic [7:0] InsWord;
  logic       InsReady;
  logic       LdEn;
  logic [1:0] LdAddr;
  logic [7:0] LdData;
  logic [1:0] RdAddr;
  logic [7:0] RdData;
  logic [1:0] InsSel;
  logic [7:0] ALUinA;
  logic [7:0] ALUinB;
  logic [7:0] ALUout;
  logic       CO;
  logic       Z;
  logic       FlagCO;
  logic       FlagZ;
  logic       Done;

  modport master (
    output InsValid, InsWord, LdEn, LdAddr, LdData, RdAddr, ALUout, CO, Z,
    input  InsReady, RdData, InsSel, ALUinA, ALUinB, FlagCO, FlagZ, Done
  );

  modport slave (
    input  InsValid, InsWord, LdEn, LdAddr, LdData, RdAddr, ALUout, CO, Z,
    output InsReady, RdData, InsSel, ALUinA, ALUinB, FlagCO, FlagZ, Done
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Three-state sequencer: accepts an instruction, fetches two operands from a
// 4x8 register file onto the ALU pins, then writes the ALU result and flags back.
module alu_op_sequencer (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] ir_q;
  logic [7:0] rf_q [4];
  logic [1:0] ins_sel_q;
  logic [7:0] alu_a_q, alu_b_q;
  logic       flag_co_q, flag_z_q;
  logic       done_q;
  logic       accept;

  assign bus.InsReady = (state_q == IDLE) && !rst;
  assign accept       = bus.InsValid && bus.InsReady;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = FETCH;
      FETCH:   state_d = EXEC;
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      rf_q      <= '{default: '0};
      ins_sel_q <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      flag_co_q <= 1'b0;
      flag_z_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // A load in the accept cycle lands before FETCH reads the file.
          if (bus.LdEn) rf_q[bus.LdAddr] <= bus.LdData;
          if (accept)   ir_q <= bus.InsWord;
        end
        FETCH: begin
          alu_a_q   <= rf_q[ir_q[3:2]];
          alu_b_q   <= rf_q[ir_q[1:0]];
          ins_sel_q <= ir_q[7:6];
        end
        EXEC: begin
          rf_q[ir_q[5:4]] <= bus.ALUout;
          flag_co_q       <= bus.CO;
          flag_z_q        <= bus.Z;
          done_q          <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.RdData = rf_q[bus.RdAddr];
  assign bus.InsSel = ins_sel_q;
  assign bus.ALUinA = alu_a_q;
  assign bus.ALUinB = alu_b_q;
  assign bus.FlagCO = flag_co_q;
  assign bus.FlagZ  = flag_z_q;
  assign bus.Done   = done_q;
endmodule
